// File: rtl/tm_input_sequencer.sv
// Front end for a Turing-machine core. It synchronises and debounces the switches and
// buttons, then turns button presses into fixed-length Next/Done strobes.
module tm_input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LEN       = 2,
  parameter int MAX_ENTRIES     = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] sw_data,
  input  logic       btn_next,
  input  logic       btn_done,
  output logic [3:0] input_data,
  output logic       Next,
  output logic       Done,
  output logic       mode,
  output logic [6:0] entry_count,
  output logic       overflow
);

  localparam logic [2:0] ENTRY_IDLE  = 3'd0;
  localparam logic [2:0] ENTRY_PULSE = 3'd1;
  localparam logic [2:0] DONE_PULSE  = 3'd2;
  localparam logic [2:0] RUN_IDLE    = 3'd3;
  localparam logic [2:0] RUN_PULSE   = 3'd4;

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] PL_LAST = 4'(PULSE_LEN - 1);
  localparam logic [6:0] MAX_CNT = 7'(MAX_ENTRIES);

  // Bit 0 is the Next button and bit 1 is the Done button.
  logic [1:0] btn_raw;
  logic [1:0] btn_sync_p0;
  logic [1:0] btn_sync_p1;
  logic [1:0] level;
  logic [1:0] press;
  logic [7:0] db_cnt [2];

  logic [3:0] sw_sync_p0;
  logic [3:0] sw_sync_p1;

  logic [2:0] state;
  logic [3:0] pcnt;

  assign btn_raw = {btn_done, btn_next};

  // Stage p0/p1: two-flop synchronisers on the asynchronous inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_sync_p0 <= '0;
      btn_sync_p1 <= '0;
      sw_sync_p0  <= '0;
      sw_sync_p1  <= '0;
    end else begin
      btn_sync_p0 <= btn_raw;
      btn_sync_p1 <= btn_sync_p0;
      sw_sync_p0  <= sw_data;
      sw_sync_p1  <= sw_sync_p0;
    end
  end

  // Debounce: the accepted level flips after DEBOUNCE_CYCLES consecutive samples
  // that disagree with it. press is a registered one-cycle pulse on a 0->1 flip.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level     <= '0;
      press     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (btn_sync_p1[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= btn_sync_p1[i];
          press[i]  <= btn_sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Sequencer: events that arrive while a strobe is active are dropped, not queued.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ENTRY_IDLE;
      pcnt        <= '0;
      input_data  <= '0;
      entry_count <= '0;
      overflow    <= 1'b0;
      mode        <= 1'b0;
    end else begin
      case (state)
        ENTRY_IDLE: begin
          if (press[1]) begin
            state <= DONE_PULSE;
            pcnt  <= '0;
          end else if (press[0]) begin
            if (entry_count == MAX_CNT) begin
              overflow <= 1'b1;
            end else begin
              input_data  <= sw_sync_p1;
              entry_count <= entry_count + 7'd1;
              state       <= ENTRY_PULSE;
              pcnt        <= '0;
            end
          end
        end
        ENTRY_PULSE: begin
          if (pcnt == PL_LAST) state <= ENTRY_IDLE;
          else pcnt <= pcnt + 4'd1;
        end
        DONE_PULSE: begin
          if (pcnt == PL_LAST) begin
            state <= RUN_IDLE;
            mode  <= 1'b1;
          end else begin
            pcnt <= pcnt + 4'd1;
          end
        end
        RUN_IDLE: begin
          if (press[0]) begin
            state <= RUN_PULSE;
            pcnt  <= '0;
          end
        end
        RUN_PULSE: begin
          if (pcnt == PL_LAST) state <= RUN_IDLE;
          else pcnt <= pcnt + 4'd1;
        end
        default: state <= ENTRY_IDLE;
      endcase
    end
  end

  // The strobes are decoded from state, so an asynchronous reset drops them at once.
  assign Next = (state == ENTRY_PULSE) || (state == RUN_PULSE);
  assign Done = (state == DONE_PULSE);

endmodule

// File: tb/tb_tm_input_sequencer.sv
// Directed bench for tm_input_sequencer: a cycle-level behavioural model is checked
// every cycle, and literal expectations for each scenario pin the model itself.
module tb_tm_input_sequencer;

  localparam int D   = 4;
  localparam int PL  = 2;
  localparam int MAX = 3;
  localparam int HN  = 8192;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw_data = 4'd0;
  logic       btn_next = 1'b0;
  logic       btn_done = 1'b0;
  logic [3:0] input_data;
  logic       Next;
  logic       Done;
  logic       mode;
  logic [6:0] entry_count;
  logic       overflow;

  int total = 0;
  int bad = 0;

  tm_input_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_LEN(PL),
    .MAX_ENTRIES(MAX)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sw_data(sw_data),
    .btn_next(btn_next),
    .btn_done(btn_done),
    .input_data(input_data),
    .Next(Next),
    .Done(Done),
    .mode(mode),
    .entry_count(entry_count),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  // The model stores raw samples per edge and applies the debounce rule to a window of them.
  bit       hn [HN];
  bit       hd [HN];
  bit [3:0] hs [HN];
  int       n = 0;
  bit       lv_n = 0, lv_d = 0, pend_n = 0, pend_d = 0;
  int       left = 0;
  bit       is_done = 0;
  bit [3:0] m_data = 0;
  int       m_cnt = 0;
  bit       m_mode = 0, m_ovf = 0;

  // The synchronised value used at edge e is the raw sample taken at edge e-2.
  function automatic bit window_all(input bit which, input bit val, input int e);
    bit s;
    for (int j = e - D - 1; j <= e - 2; j++) begin
      s = (j < 0) ? 1'b0 : (which ? hd[j] : hn[j]);
      if (s != val) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        n = 0; lv_n = 0; lv_d = 0; pend_n = 0; pend_d = 0;
        left = 0; is_done = 0; m_data = 0; m_cnt = 0; m_mode = 0; m_ovf = 0;
      end else if (n < HN) begin
        hn[n] = btn_next; hd[n] = btn_done; hs[n] = sw_data;
        if (left > 0) begin
          left--;
          if (left == 0 && is_done) m_mode = 1;
        end else if (pend_d && !m_mode) begin
          left = PL; is_done = 1;
        end else if (pend_n) begin
          if (m_mode) begin
            left = PL; is_done = 0;
          end else if (m_cnt < MAX) begin
            m_data = (n >= 2) ? hs[n - 2] : 4'd0;
            m_cnt++; left = PL; is_done = 0;
          end else begin
            m_ovf = 1;
          end
        end
        pend_n = 0; pend_d = 0;
        if (window_all(1'b0, !lv_n, n)) begin lv_n = !lv_n; pend_n = lv_n; end
        if (window_all(1'b1, !lv_d, n)) begin lv_d = !lv_d; pend_d = lv_d; end
        n++;
      end
    end
  end

  int next_pulses = 0, done_pulses = 0, next_hi = 0, done_hi = 0;

  initial begin
    logic [14:0] act, exp;
    bit pn = 0, pd = 0;
    forever begin
      @(negedge clock);
      act = {input_data, Next, Done, mode, entry_count, overflow};
      exp = {m_data, (left > 0) && !is_done, (left > 0) && is_done, m_mode, 7'(m_cnt), m_ovf};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL model_cycle t=%0t: dut=%h model=%h", $time, act, exp);
      end
      total++;
      if ((Next & Done) !== 1'b0) begin
        bad++;
        $display("FAIL strobe_overlap t=%0t: Next=%b Done=%b required not both", $time, Next, Done);
      end
      if (Next === 1'b1) next_hi++;
      if (Done === 1'b1) done_hi++;
      if (Next === 1'b1 && !pn) next_pulses++;
      if (Done === 1'b1 && !pd) done_pulses++;
      pn = (Next === 1'b1);
      pd = (Done === 1'b1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic press_next(input logic [3:0] v, input int hold, input int gap);
    sw_data = v;
    @(negedge clock);
    btn_next = 1'b1;
    repeat (hold) @(negedge clock);
    btn_next = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic wait_next(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clock);
      #1;
      if (Next === 1'b1) seen = 1;
    end
    check(name, seen, 1);
  endtask

  initial begin
    int np, dp, nh, dh, first, ones, cnt0;
    bit nx [24];

    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_state", {input_data, Next, Done, mode, entry_count, overflow}, 15'd0);

    // Table overflow with MAX_ENTRIES=3.
    np = next_pulses;
    press_next(4'd1, 10, 12);
    press_next(4'd2, 10, 12);
    press_next(4'd0, 10, 12);
    check("ovf_before_full_press", overflow, 0);
    press_next(4'd1, 10, 12);
    check("ovf_next_pulses", next_pulses - np, 3);
    check("ovf_input_data", input_data, 0);
    check("ovf_entry_count", entry_count, 3);
    check("ovf_flag", overflow, 1);

    // Single held press: latency and width.
    do_reset();
    nh = next_hi; np = next_pulses;
    sw_data = 4'd3;
    @(negedge clock);
    btn_next = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clock);
      #1;
      nx[i] = Next;
    end
    @(negedge clock);
    btn_next = 1'b0;
    repeat (12) @(negedge clock);
    first = -1; ones = 0;
    for (int i = 0; i < 24; i++) begin
      if (nx[i]) begin
        ones++;
        if (first < 0) first = i;
      end
    end
    check("held_first_rise_edge", first, 6);
    check("held_width", ones, 2);
    check("held_pulses", next_pulses - np, 1);
    check("held_input_data", input_data, 3);
    check("held_entry_count", entry_count, 1);

    // Bouncing button never settles long enough.
    np = next_pulses;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      btn_next = ~btn_next;
    end
    @(negedge clock);
    btn_next = 1'b0;
    repeat (20) @(negedge clock);
    check("bounce_no_pulse", next_pulses - np, 0);
    check("bounce_entry_count", entry_count, 1);

    // Done press debounced while a Next pulse is active is dropped.
    np = next_pulses; dp = done_pulses;
    sw_data = 4'd2;
    @(negedge clock);
    btn_next = 1'b1;
    @(negedge clock);
    btn_done = 1'b1;
    repeat (10) @(negedge clock);
    btn_next = 1'b0;
    btn_done = 1'b0;
    repeat (14) @(negedge clock);
    check("drop_next_pulses", next_pulses - np, 1);
    check("drop_done_pulses", done_pulses - dp, 0);
    check("drop_mode", mode, 0);
    check("drop_entry_count", entry_count, 2);
    check("drop_input_data", input_data, 2);

    // Reset in the second Next cycle, button held through reset.
    do_reset();
    sw_data = 4'd7;
    @(negedge clock);
    btn_next = 1'b1;
    wait_next("midreset_first_pulse", 20);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_next", Next, 0);
    check("midreset_outputs", {input_data, Next, Done, mode, entry_count, overflow}, 15'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    wait_next("held_through_reset_press", 20);
    @(negedge clock);
    btn_next = 1'b0;
    repeat (14) @(negedge clock);
    check("held_through_reset_count", entry_count, 1);
    check("held_through_reset_data", input_data, 7);

    // Simultaneous next and done: done wins, then RUN mode.
    np = next_pulses; dp = done_pulses; dh = done_hi;
    cnt0 = entry_count;
    @(negedge clock);
    btn_next = 1'b1;
    btn_done = 1'b1;
    repeat (12) @(negedge clock);
    btn_next = 1'b0;
    btn_done = 1'b0;
    repeat (14) @(negedge clock);
    check("both_done_pulses", done_pulses - dp, 1);
    check("both_done_width", done_hi - dh, 2);
    check("both_no_next", next_pulses - np, 0);
    check("both_mode", mode, 1);
    np = next_pulses;
    press_next(4'd5, 10, 14);
    check("run_next_pulses", next_pulses - np, 1);
    check("run_entry_count", entry_count, cnt0);
    check("run_input_data", input_data, 7);
    dp = done_pulses;
    @(negedge clock);
    btn_done = 1'b1;
    repeat (10) @(negedge clock);
    btn_done = 1'b0;
    repeat (14) @(negedge clock);
    check("run_done_ignored", done_pulses - dp, 0);
    check("run_mode_sticky", mode, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
